// File: rtl/fetch_pc_unit_if.sv
// fetch_pc_unit_if: shared types and the fetch-stage bus between pipeline control and the PC unit
package fetch_pc_pkg;
  typedef logic [31:0] WORD;
  typedef enum logic [1:0] {
    NO_STALL_PIPELINE = 2'd0,
    STALL_PIPELINE    = 2'd1
  } stall_pipeline_sig;
endpackage

// Inputs: load mode, stall, branch redirect. Outputs: fetch address/valid, decode PC, fetch count.
interface fetch_pc_unit_if;
  import fetch_pc_pkg::*;
  logic              program_mem_write_en_i;
  stall_pipeline_sig stall_pipeline_i;
  logic              branch_taken_i;
  WORD               branch_target_i;
  WORD               instruction_addr_o;
  logic              is_valid_o;
  WORD               decode_pc_o;
  WORD               fetch_count_o;
  modport master (
    output program_mem_write_en_i, stall_pipeline_i, branch_taken_i, branch_target_i,
    input  instruction_addr_o, is_valid_o, decode_pc_o, fetch_count_o
  );
  modport slave (
    input  program_mem_write_en_i, stall_pipeline_i, branch_taken_i, branch_target_i,
    output instruction_addr_o, is_valid_o, decode_pc_o, fetch_count_o
  );
endinterface

// File: rtl/fetch_pc_unit.sv
// fetch_pc_unit: Thumb fetch PC stage with stall hold, branch redirect, load-mode park and fetch counter
// Ports: clk_i rising-edge clock; reset_i async active-low reset; bus (slave) carries
// load/stall/branch inputs and fetch address, valid, decode-aligned PC and saturating count.
module fetch_pc_unit
  import fetch_pc_pkg::*;
#(
  parameter WORD RESET_VECTOR = 32'h0000_0000
) (
  input logic           clk_i,
  input logic           reset_i,
  fetch_pc_unit_if.slave bus
);
  typedef enum logic [1:0] {IDLE, LOAD, RUN} state_t;
  localparam WORD PC_RESET = {RESET_VECTOR[31:1], 1'b0};
  state_t fsm_q, fsm_d;
  WORD    fetch_pc_q, fetch_pc_d;
  WORD    decode_pc_q, decode_pc_d;
  WORD    fetch_count_q, fetch_count_d;
  logic   run, stall, br, valid;
  always_comb begin
    run   = fsm_q == RUN;
    stall = bus.stall_pipeline_i != NO_STALL_PIPELINE;
    br    = bus.branch_taken_i;
    valid = run & ~br;
    // Every state leaves for LOAD while loading and for RUN otherwise.
    fsm_d = bus.program_mem_write_en_i ? LOAD : RUN;
    // A branch beats a stall: the stalled instruction is younger and gets squashed.
    fetch_pc_d = (!run || bus.program_mem_write_en_i) ? PC_RESET :
                 br    ? {bus.branch_target_i[31:1], 1'b0} :
                 stall ? fetch_pc_q : fetch_pc_q + 32'd2;
    // Tracks instruction_mem's stored PC so decode_pc_o lines up with its output word.
    decode_pc_d   = (!stall || br) ? fetch_pc_q : decode_pc_q;
    fetch_count_d = (valid && !stall && fetch_count_q != 32'hFFFF_FFFF) ? fetch_count_q + 32'd1 : fetch_count_q;
  end
  always_ff @(posedge clk_i or negedge reset_i)
    if (!reset_i) begin
      fsm_q         <= IDLE;
      fetch_pc_q    <= PC_RESET;
      decode_pc_q   <= '0;
      fetch_count_q <= '0;
    end else begin
      fsm_q         <= fsm_d;
      fetch_pc_q    <= fetch_pc_d;
      decode_pc_q   <= decode_pc_d;
      fetch_count_q <= fetch_count_d;
    end
  assign bus.instruction_addr_o = fetch_pc_q;
  assign bus.is_valid_o         = valid;
  assign bus.decode_pc_o        = decode_pc_q;
  assign bus.fetch_count_o      = fetch_count_q;
endmodule

// File: tb/tb_fetch_pc_unit.sv
// tb_fetch_pc_unit: directed scoreboard bench for fetch_pc_unit
module tb_fetch_pc_unit;
  import fetch_pc_pkg::*;
  typedef struct {
    string       name;
    logic [31:0] addr;
    logic        valid;
    logic [31:0] dpc;
    logic [31:0] cnt;
  } exp_t;
  logic clk = 1'b0;
  logic reset_i = 1'b1;
  int   pass_cnt = 0;
  int   total_cnt = 0;
  exp_t sb[$];
  fetch_pc_unit_if bus();
  fetch_pc_unit #(.RESET_VECTOR(32'h0000_0081)) u_dut (
    .clk_i  (clk),
    .reset_i(reset_i),
    .bus    (bus.slave)
  );
  always #5 clk = ~clk;
  function automatic void chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h want %h", n, act, exp);
  endfunction
  task automatic step(input string n, input logic we, input logic st, input logic br,
                      input logic [31:0] tgt, input logic [31:0] ea, input logic ev,
                      input logic [31:0] ed, input logic [31:0] ec);
    @(negedge clk);
    bus.program_mem_write_en_i = we;
    bus.stall_pipeline_i       = st ? STALL_PIPELINE : NO_STALL_PIPELINE;
    bus.branch_taken_i         = br;
    bus.branch_target_i        = tgt;
    sb.push_back('{name: n, addr: ea, valid: ev, dpc: ed, cnt: ec});
  endtask
  initial begin
    exp_t e;
    forever begin
      @(negedge clk or negedge reset_i);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk({e.name, ".addr"}, bus.instruction_addr_o, e.addr);
        chk({e.name, ".valid"}, {31'd0, bus.is_valid_o}, {31'd0, e.valid});
        chk({e.name, ".dpc"}, bus.decode_pc_o, e.dpc);
        chk({e.name, ".cnt"}, bus.fetch_count_o, e.cnt);
      end
    end
  end
  initial begin
    bus.program_mem_write_en_i = 1'b0;
    bus.stall_pipeline_i       = NO_STALL_PIPELINE;
    bus.branch_taken_i         = 1'b0;
    bus.branch_target_i        = '0;
    #2;
    sb.push_back('{name: "rst0", addr: 32'h80, valid: 1'b0, dpc: 32'h0, cnt: 32'h0});
    reset_i = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset_i = 1'b1;
    step("idle", 0, 0, 0, 32'h0,   32'h80, 0, 32'h0,  32'h0);
    step("run1", 0, 0, 0, 32'h0,   32'h80, 1, 32'h80, 32'h0);
    step("run2", 0, 0, 0, 32'h0,   32'h82, 1, 32'h80, 32'h1);
    step("run3", 0, 0, 0, 32'h0,   32'h84, 1, 32'h82, 32'h2);
    step("run4", 0, 0, 0, 32'h0,   32'h86, 1, 32'h84, 32'h3);
    step("run5", 0, 0, 0, 32'h0,   32'h88, 1, 32'h86, 32'h4);
    step("run6", 0, 0, 0, 32'h0,   32'h8A, 1, 32'h88, 32'h5);
    step("run7", 0, 0, 0, 32'h0,   32'h8C, 1, 32'h8A, 32'h6);
    step("run8", 0, 0, 0, 32'h0,   32'h8E, 1, 32'h8C, 32'h7);
    step("stl1", 0, 1, 0, 32'h0,   32'h90, 1, 32'h8E, 32'h8);
    step("stl2", 0, 1, 0, 32'h0,   32'h90, 1, 32'h8E, 32'h8);
    step("stl3", 0, 1, 0, 32'h0,   32'h90, 1, 32'h8E, 32'h8);
    step("go90", 0, 0, 0, 32'h0,   32'h90, 1, 32'h8E, 32'h8);
    step("br1",  0, 0, 1, 32'h101, 32'h92, 0, 32'h90, 32'h9);
    step("tgt1", 0, 0, 0, 32'h0,   32'h100, 1, 32'h92, 32'h9);
    step("brst", 0, 1, 1, 32'h40,  32'h102, 0, 32'h100, 32'hA);
    step("tgt2", 0, 0, 0, 32'h0,   32'h40, 1, 32'h102, 32'hA);
    step("ld1",  1, 0, 0, 32'h0,   32'h42, 1, 32'h40, 32'hB);
    step("ld2",  1, 0, 0, 32'h0,   32'h80, 0, 32'h42, 32'hC);
    step("ld3",  1, 0, 0, 32'h0,   32'h80, 0, 32'h80, 32'hC);
    step("ld4",  1, 0, 0, 32'h0,   32'h80, 0, 32'h80, 32'hC);
    step("ld5",  1, 0, 0, 32'h0,   32'h80, 0, 32'h80, 32'hC);
    step("ldx",  0, 0, 0, 32'h0,   32'h80, 0, 32'h80, 32'hC);
    step("rel1", 0, 0, 0, 32'h0,   32'h80, 1, 32'h80, 32'hC);
    step("brw",  0, 0, 1, 32'hFFFF_FFFF, 32'h82, 0, 32'h80, 32'hD);
    step("top",  0, 0, 0, 32'h0,   32'hFFFF_FFFE, 1, 32'h82, 32'hD);
    step("wrap", 0, 0, 0, 32'h0,   32'h0, 1, 32'hFFFF_FFFE, 32'hE);
    @(posedge clk);
    #2 force u_dut.fetch_count_q = 32'hFFFF_FFFD;
    #1 release u_dut.fetch_count_q;
    step("sat1", 0, 0, 0, 32'h0,   32'h2, 1, 32'h0, 32'hFFFF_FFFD);
    step("sat2", 0, 0, 0, 32'h0,   32'h4, 1, 32'h2, 32'hFFFF_FFFE);
    step("sat3", 0, 0, 0, 32'h0,   32'h6, 1, 32'h4, 32'hFFFF_FFFF);
    step("sat4", 0, 0, 0, 32'h0,   32'h8, 1, 32'h6, 32'hFFFF_FFFF);
    step("brst2", 0, 1, 1, 32'h200, 32'hA, 0, 32'h8, 32'hFFFF_FFFF);
    #3;
    sb.push_back('{name: "arst", addr: 32'h80, valid: 1'b0, dpc: 32'h0, cnt: 32'h0});
    reset_i = 1'b0;
    for (int i = 0; i < 20 && sb.size() > 0; i++) @(negedge clk);
    #2;
    if (sb.size() > 0) begin
      total_cnt++;
      $display("FAIL drain: got %0d pending want 0", sb.size());
    end
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
